// File: rtl/flag_sync_tracker_if.sv
// Tracker-side bundle: upstream flags and clock enable in, phase reference out.
interface flag_sync_tracker_if #(
   parameter int CNT_WIDTH = 4,
   parameter int ERR_WIDTH = 8
);
   logic                 clk_en;
   logic [1:0]           flag_i;
   logic [CNT_WIDTH-1:0] cnt_o;
   logic                 locked;
   logic                 sync_err;
   logic [ERR_WIDTH-1:0] err_cnt;

   modport master (
      output clk_en, flag_i,
      input  cnt_o, locked, sync_err, err_cnt
   );

   modport slave (
      input  clk_en, flag_i,
      output cnt_o, locked, sync_err, err_cnt
   );
endinterface

// File: rtl/flag_sync_tracker.sv
// Rebuilds the upstream count from its match flags; locks and reports slips.
// Define FLAG_SYNC_TRACKER_ERR_CNT_EN to implement the saturating err_cnt.
module flag_sync_tracker #(
   parameter int CNT_WIDTH = 4,
   parameter int FLAG0_VAL = 1,
   parameter int FLAG1_VAL = 0,
   parameter int LOCK_CNT  = 2,
   parameter int ERR_WIDTH = 8
) (
   input logic                clk,
   input logic                rst_n,
   flag_sync_tracker_if.slave bus
);

   localparam int MW = $clog2(LOCK_CNT + 1);

   generate
      if (FLAG0_VAL == FLAG1_VAL || LOCK_CNT < 1) begin : g_bad_param
         $error("flag_sync_tracker: illegal FLAG*_VAL or LOCK_CNT");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_HUNT,
      S_CHECK,
      S_LOCKED
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic [CNT_WIDTH-1:0] w_cnt_nxt;
   logic [CNT_WIDTH-1:0] w_cnt_inc;
   logic [MW-1:0]        r_match;
   logic [MW-1:0]        w_match_nxt;
   logic [MW-1:0]        w_match_inc;
   logic                 r_sync_err;
   logic                 w_sync_err_nxt;
   logic [1:0]           w_exp;
   logic                 w_mis;
   logic                 w_evt;

   assign w_exp[0]    = (r_cnt == CNT_WIDTH'(FLAG0_VAL));
   assign w_exp[1]    = (r_cnt == CNT_WIDTH'(FLAG1_VAL));
   assign w_mis       = (bus.flag_i != w_exp);
   assign w_evt       = bus.clk_en && !w_mis && (bus.flag_i != 2'b00);
   assign w_cnt_inc   = r_cnt + CNT_WIDTH'(bus.clk_en);
   assign w_match_inc = r_match + MW'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_HUNT;
         r_cnt      <= '0;
         r_match    <= '0;
         r_sync_err <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_match    <= w_match_nxt;
         r_sync_err <= w_sync_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_match_nxt    = r_match;
      w_sync_err_nxt = 1'b0;
      unique case (r_state)
         S_HUNT: begin
            // Only a lone flag[1] pins the phase unambiguously
            if (bus.flag_i == 2'b10) begin
               w_cnt_nxt   = CNT_WIDTH'(FLAG1_VAL) + CNT_WIDTH'(bus.clk_en);
               w_match_nxt = '0;
               w_state_nxt = S_CHECK;
            end
         end
         S_CHECK: begin
            w_cnt_nxt = w_cnt_inc;
            if (w_mis) begin
               w_match_nxt = '0;
               w_state_nxt = S_HUNT;
            end else if (w_evt) begin
               w_match_nxt = w_match_inc;
               if (w_match_inc == MW'(LOCK_CNT))
                  w_state_nxt = S_LOCKED;
            end
         end
         S_LOCKED: begin
            w_cnt_nxt = w_cnt_inc;
            if (w_mis) begin
               w_sync_err_nxt = 1'b1;
               w_match_nxt    = '0;
               w_state_nxt    = S_HUNT;
            end
         end
         default: begin
            w_match_nxt = '0;
            w_state_nxt = S_HUNT;
         end
      endcase
   end

`ifdef FLAG_SYNC_TRACKER_ERR_CNT_EN
   logic [ERR_WIDTH-1:0] r_err_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_err_cnt <= '0;
      else if (w_sync_err_nxt && (r_err_cnt != '1))
         r_err_cnt <= r_err_cnt + ERR_WIDTH'(1);
   end

   assign bus.err_cnt = r_err_cnt;
`else
   assign bus.err_cnt = '0;
`endif

   assign bus.cnt_o    = r_cnt;
   assign bus.locked   = (r_state == S_LOCKED);
   assign bus.sync_err = r_sync_err;

endmodule
